sbox_sched: RTL

SBOX_SCHED -- requirements
Module: sbox_sched

---
 rtl/sbox_sched_pkg.sv | 20 ++
 rtl/sbox_sched_arb.sv | 41 ++++
 rtl/sbox_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sbox_sched_pkg.sv
// rtl/sbox_sched_pkg.sv - shared types and constants for the S-box scheduler
// Purpose: FSM state encoding, job sizes in bytes, and job-owner encoding.
// Ports:   none (package).
package sbox_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int KEY_BYTES  = 4;
  localparam int DATA_BYTES = 16;

  typedef enum logic {
    OWN_KEY  = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/sbox_sched_arb.sv
// rtl/sbox_sched_arb.sv - two-requester arbiter with last-served tie-break
// Purpose: choose key or data requester; on a tie grant the one not served
//          last. After reset the last-served pointer names data, so key wins.
// Ports:   clk, reset_n     - clock, async active-low reset
//          key_req,data_req - pending requests
//          grant_en         - a grant is taken this cycle (updates pointer)
//          grant_data       - 1 = data requester granted, 0 = key
import sbox_sched_pkg::*;

module sbox_sched_arb (
  input  logic clk,
  input  logic reset_n,
  input  logic key_req,
  input  logic data_req,
  input  logic grant_en,
  output logic grant_data
);

  owner_t last_q;
  owner_t grant;

  always_comb begin
    grant = OWN_KEY;
    if (key_req && data_req) begin
      grant = (last_q == OWN_KEY) ? OWN_DATA : OWN_KEY;
    end else if (data_req) begin
      grant = OWN_DATA;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= OWN_DATA;
    end else if (grant_en) begin
      last_q <= grant;
    end
  end

  assign grant_data = (grant == OWN_DATA);

endmodule

// File: rtl/sbox_sched.sv
// rtl/sbox_sched.sv - time-shares one external S-box between key and data jobs
// Purpose: FSM IDLE -> RUN -> ACK -> IDLE. A key job substitutes 4 bytes
//          (forward S-box), a data job 16 bytes (forward or inverse), one byte
//          per RUN cycle, then pulses the owner's ack for one cycle.
//          Optional macro SBOX_SCHED_PIPE_EN registers sbox_out and captures it
//          one cycle late, adding one RUN cycle per job.
// Ports:   clk, reset_n                     - clock, async active-low reset
//          key_req/key_word/key_ack/key_result       - key requester
//          data_req/data_encrypt/data_block/data_ack/data_result - data requester
//          sbox_in, sbox_encrypt, sbox_out  - external combined S-box
//          busy                             - high whenever not IDLE
import sbox_sched_pkg::*;

module sbox_sched (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_req,
  input  logic [31:0]  key_word,
  output logic         key_ack,
  output logic [31:0]  key_result,
  input  logic         data_req,
  input  logic         data_encrypt,
  input  logic [127:0] data_block,
  output logic         data_ack,
  output logic [127:0] data_result,
  output logic [7:0]   sbox_in,
  output logic         sbox_encrypt,
  input  logic [7:0]   sbox_out,
  output logic         busy
);

  state_t       state_q, state_d;
  owner_t       owner_q;
  logic [3:0]   cnt_q;
  logic [31:0]  key_op_q;
  logic [127:0] data_op_q;
  logic         enc_q;
  logic         grant_en;
  logic         grant_data;
  logic [3:0]   last_idx;
  logic         run_done;
  logic         cap_vld;
  logic [3:0]   cap_idx;
  logic [7:0]   cap_byte;

  sbox_sched_arb u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_req    (key_req),
    .data_req   (data_req),
    .grant_en   (grant_en),
    .grant_data (grant_data)
  );

  assign last_idx = (owner_q == OWN_DATA) ? 4'(DATA_BYTES - 1) : 4'(KEY_BYTES - 1);

`ifdef SBOX_SCHED_PIPE_EN
  // Byte i is driven in RUN cycle i and written one cycle later; drain_q
  // marks the extra RUN cycle in which only the last byte is written.
  logic       drain_q;
  logic       pipe_vld_q;
  logic [3:0] pipe_idx_q;
  logic [7:0] pipe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drain_q    <= 1'b0;
      pipe_vld_q <= 1'b0;
      pipe_idx_q <= 4'd0;
      pipe_q     <= 8'h00;
    end else if (state_q == ST_RUN) begin
      pipe_q     <= sbox_out;
      pipe_idx_q <= cnt_q;
      pipe_vld_q <= !drain_q;
      if (cnt_q == last_idx) drain_q <= 1'b1;
    end else begin
      drain_q    <= 1'b0;
      pipe_vld_q <= 1'b0;
    end
  end

  assign run_done = drain_q;
  assign cap_vld  = (state_q == ST_RUN) && pipe_vld_q;
  assign cap_idx  = pipe_idx_q;
  assign cap_byte = pipe_q;
`else
  assign run_done = (cnt_q == last_idx);
  assign cap_vld  = (state_q == ST_RUN);
  assign cap_idx  = cnt_q;
  assign cap_byte = sbox_out;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ACK always returns to IDLE so a waiting requester is arbitrated fresh.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_req || data_req) begin
          grant_en = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN:  if (run_done) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q     <= OWN_KEY;
      cnt_q       <= 4'd0;
      key_op_q    <= 32'h0;
      data_op_q   <= 128'h0;
      enc_q       <= 1'b1;
      key_result  <= 32'h0;
      data_result <= 128'h0;
    end else begin
      if (grant_en) begin
        owner_q <= grant_data ? OWN_DATA : OWN_KEY;
        cnt_q   <= 4'd0;
        if (grant_data) begin
          data_op_q <= data_block;
          enc_q     <= data_encrypt;
        end else begin
          key_op_q <= key_word;
          enc_q    <= 1'b1;
        end
      end
      // Counter saturates on the last byte; no wrap-around.
      if (state_q == ST_RUN && cnt_q != last_idx) cnt_q <= cnt_q + 4'd1;
      if (cap_vld) begin
        if (owner_q == OWN_DATA) data_result[{cap_idx, 3'b000} +: 8] <= cap_byte;
        else                     key_result[{cap_idx[1:0], 3'b000} +: 8] <= cap_byte;
      end
    end
  end

  always_comb begin
    sbox_in = 8'h00;
    if (state_q == ST_RUN) begin
      if (owner_q == OWN_DATA) sbox_in = data_op_q[{cnt_q, 3'b000} +: 8];
      else                     sbox_in = key_op_q[{cnt_q[1:0], 3'b000} +: 8];
    end
  end

  assign sbox_encrypt = (state_q == ST_IDLE) ? 1'b1 : enc_q;
  assign busy         = (state_q != ST_IDLE);
  assign key_ack      = (state_q == ST_ACK) && (owner_q == OWN_KEY);
  assign data_ack     = (state_q == ST_ACK) && (owner_q == OWN_DATA);

endmodule
